// File: rtl/miner_pkg.sv
// Shared definitions for the miner result-reporting path.
//   NONCE_W         : width of a winning nonce
//   DATA_BITS       : data bits per UART character (8N1 framing)
//   BYTES_PER_NONCE : UART characters sent per nonce
//   uart_state_e    : transmitter FSM state encoding
package miner_pkg;

  localparam int NONCE_W         = 32;
  localparam int DATA_BITS       = 8;
  localparam int BYTES_PER_NONCE = 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous single-clock FIFO with show-ahead read data.
// Ports:
//   osc_clk  : clock, rising edge
//   rst      : synchronous active-high reset (flushes the FIFO)
//   wr_en    : push wr_data (ignored when full unless a pop happens the same edge)
//   wr_data  : data to push
//   rd_en    : pop the head (ignored when empty)
//   rd_data  : current head, valid whenever empty=0
//   count    : number of stored entries
//   full     : count == DEPTH
//   empty    : count == 0
module nonce_fifo
  import miner_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = NONCE_W
) (
  input  logic                     osc_clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             rd_ok;
  logic             wr_ok;

  // A write into a full FIFO is legal when the head leaves on the same edge:
  // the head slot is read combinationally before it is overwritten.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge osc_clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; pointers alone define what is valid.
  always_ff @(posedge osc_clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/nonce_uart_reporter.sv
// Buffers winning nonces from the miner and reports each one to the host as
// four 8N1 UART characters, most significant byte first, LSB-first bits.
// Ports:
//   osc_clk        : system clock, rising edge
//   rst            : synchronous active-high reset
//   nonce_valid    : one-cycle pulse, nonce carries a winning result
//   nonce          : winning nonce, sampled when nonce_valid=1
//   tx             : registered UART line, idle high
//   busy           : FIFO non-empty or a frame is still on the line
//   fifo_count     : entries currently buffered
//   overflow_count : nonces dropped on a full FIFO, saturating at 16'hFFFF
module nonce_uart_reporter
  import miner_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          osc_clk,
  input  logic                          rst,
  input  logic                          nonce_valid,
  input  logic [NONCE_W-1:0]            nonce,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   overflow_count
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int CW           = $clog2(FIFO_DEPTH) + 1;
  localparam int BIT_W        = $clog2(DATA_BITS);
  localparam int BYTE_W       = $clog2(BYTES_PER_NONCE);

  uart_state_e          state, state_nxt;
  logic [CNT_W-1:0]     baud_cnt, baud_cnt_nxt;
  logic [BIT_W-1:0]     bit_idx, bit_idx_nxt;
  logic [BYTE_W-1:0]    byte_idx, byte_idx_nxt;
  logic [NONCE_W-1:0]   shift_word;
  logic [DATA_BITS-1:0] cur_byte;
  logic                 baud_done;
  logic                 pop;
  logic                 shift_byte;
  logic                 tx_nxt;

  logic [NONCE_W-1:0]   fifo_rd_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_wr;
  logic                 drop;
  logic [CW-1:0]        count_nxt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A nonce arriving on the pop edge always fits, even when the FIFO is full.
  assign fifo_wr   = nonce_valid & (~fifo_full | pop);
  assign drop      = nonce_valid & fifo_full & ~pop;
  assign count_nxt = fifo_count + CW'(fifo_wr) - CW'(pop);

  nonce_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (NONCE_W)
  ) u_fifo (
    .osc_clk (osc_clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (nonce),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // The byte on the wire always sits in the top of the shift word.
  assign cur_byte  = shift_word[NONCE_W-1 -: DATA_BITS];
  assign baud_done = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt + CNT_W'(1);
    bit_idx_nxt  = bit_idx;
    byte_idx_nxt = byte_idx;
    pop          = 1'b0;
    shift_byte   = 1'b0;
    tx_nxt       = 1'b1;
    case (state)
      IDLE: begin
        baud_cnt_nxt = '0;
        if (!fifo_empty) begin
          pop          = 1'b1;
          byte_idx_nxt = '0;
          state_nxt    = START;
        end
      end
      START: begin
        tx_nxt = 1'b0;
        if (baud_done) begin
          baud_cnt_nxt = '0;
          bit_idx_nxt  = '0;
          state_nxt    = DATA;
        end
      end
      DATA: begin
        tx_nxt = cur_byte[bit_idx];
        if (baud_done) begin
          baud_cnt_nxt = '0;
          if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx + BIT_W'(1);
          end
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_cnt_nxt = '0;
          shift_byte   = 1'b1;
          if (byte_idx == BYTE_W'(BYTES_PER_NONCE - 1)) begin
            state_nxt = IDLE;
          end else begin
            byte_idx_nxt = byte_idx + BYTE_W'(1);
            state_nxt    = START;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // tx is registered from the current state, so the line lags the FSM by one
  // cycle; busy covers that lag by also holding while the FSM was active on
  // the previous cycle, while still rising together with fifo_count.
  always_ff @(posedge osc_clk) begin
    if (rst) begin
      state          <= IDLE;
      baud_cnt       <= '0;
      bit_idx        <= '0;
      byte_idx       <= '0;
      tx             <= 1'b1;
      busy           <= 1'b0;
      overflow_count <= '0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      byte_idx <= byte_idx_nxt;
      tx       <= tx_nxt;
      busy     <= (state_nxt != IDLE) | (count_nxt != '0) | (state != IDLE);
      if (drop) overflow_count <= sat_inc16(overflow_count);
    end
  end

  always_ff @(posedge osc_clk) begin
    if (pop) begin
      shift_word <= fifo_rd_data;
    end else if (shift_byte) begin
      shift_word <= {shift_word[NONCE_W-DATA_BITS-1:0], {DATA_BITS{1'b0}}};
    end
  end

endmodule

// File: tb/tb_nonce_uart_reporter.sv
// Bench for nonce_uart_reporter: every cycle compares tx, busy, fifo_count and
// overflow_count against a reference built from a queue of buffered nonces and
// the edge at which the transmitter last took a nonce.
module tb_nonce_uart_reporter;

  localparam int CPB   = 10;
  localparam int FRAME = 40 * CPB;
  localparam int DEPTH = 4;

  logic        osc_clk = 1'b0;
  logic        rst = 1'b0;
  logic        nonce_valid = 1'b0;
  logic [31:0] nonce = '0;
  logic        tx;
  logic        busy;
  logic [2:0]  fifo_count;
  logic [15:0] overflow_count;

  nonce_uart_reporter #(
    .CLK_HZ     (50000000),
    .BAUD       (5000000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .osc_clk        (osc_clk),
    .rst            (rst),
    .nonce_valid    (nonce_valid),
    .nonce          (nonce),
    .tx             (tx),
    .busy           (busy),
    .fifo_count     (fifo_count),
    .overflow_count (overflow_count)
  );

  always #5 osc_clk = ~osc_clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference state
  int          cyc = 0;
  logic [31:0] mq[$];
  int          m_ovf = 0;
  bit          has_frame = 1'b0;
  int          last_pop = 0;
  int          next_pop_ok = 0;
  logic [31:0] cur_nonce = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $display("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
      $error("miscompare on %s", tag);
    end
  endtask

  // Line level after edge e: 40 bit slots of CPB cycles starting the cycle
  // after the pop edge; slot 0 of each character is the start bit, slot 9 stop.
  function automatic logic exp_tx(input int e);
    int k, bp, by, b;
    if (!has_frame) return 1'b1;
    k = e - last_pop - 1;
    if (k < 0 || k >= FRAME) return 1'b1;
    bp = k / CPB;
    by = bp / 10;
    b  = bp % 10;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur_nonce[8 * (3 - by) + b - 1];
  endfunction

  function automatic logic exp_busy(input int e);
    return (mq.size() != 0) || (has_frame && e <= last_pop + FRAME);
  endfunction

  function automatic bit model_active();
    return (mq.size() != 0) || (has_frame && cyc <= last_pop + FRAME + 1);
  endfunction

  task automatic step(input logic r, input logic v, input logic [31:0] d);
    int e;
    bit pop;
    rst = r;
    nonce_valid = v;
    nonce = d;
    @(posedge osc_clk);
    e = cyc;
    cyc++;
    if (r) begin
      mq.delete();
      m_ovf = 0;
      has_frame = 1'b0;
      next_pop_ok = 0;
    end else begin
      pop = (mq.size() > 0) && (e >= next_pop_ok);
      if (pop) begin
        cur_nonce = mq.pop_front();
        has_frame = 1'b1;
        last_pop = e;
        next_pop_ok = e + FRAME + 1;
      end
      if (v) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else if (m_ovf < 65535) m_ovf++;
      end
    end
    #1;
    chk("tx", 32'(tx), 32'(exp_tx(e)));
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("busy", 32'(busy), 32'(exp_busy(e)));
    chk("overflow_count", 32'(overflow_count), 32'(m_ovf));
  endtask

  task automatic drain();
    for (int i = 0; i < 5000; i++) begin
      if (!model_active()) break;
      step(1'b0, 1'b0, 32'h0);
    end
    repeat (3) step(1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    int p;
    int ovf_before;
    logic [31:0] d;

    // Reset
    repeat (3) step(1'b1, 1'b0, 32'h0);
    repeat (2) step(1'b0, 1'b0, 32'h0);

    // Single nonce, latency and busy fall
    step(1'b0, 1'b1, 32'hDEADBEEF);
    chk("t2_count_capture", 32'(fifo_count), 32'd1);
    step(1'b0, 1'b0, 32'h0);
    chk("t2_tx_pop_edge", 32'(tx), 32'd1);
    p = cyc - 1;
    step(1'b0, 1'b0, 32'h0);
    chk("t2_tx_start", 32'(tx), 32'd0);
    while (cyc <= p + FRAME) step(1'b0, 1'b0, 32'h0);
    chk("t2_busy_hold", 32'(busy), 32'd1);
    step(1'b0, 1'b0, 32'h0);
    chk("t2_busy_fall", 32'(busy), 32'd0);
    drain();

    // Burst of six, last one dropped
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 1'b1, 32'(i));
      if (i == 5) chk("t3_count_full", 32'(fifo_count), 32'd4);
      if (i == 6) chk("t3_ovf_one", 32'(overflow_count), 32'd1);
    end
    drain();

    // Full FIFO plus a pulse on the exact pop edge
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, $urandom);
    ovf_before = m_ovf;
    for (int i = 0; i < 1000 && cyc != next_pop_ok; i++) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, $urandom);
    chk("t4_count_stays", 32'(fifo_count), 32'd4);
    chk("t4_ovf_same", 32'(overflow_count), 32'(ovf_before));
    drain();

    // Reset during DATA bit 3 of byte 1 with two nonces queued
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, $urandom);
    for (int i = 0; i < 1000 && cyc != last_pop + 145; i++) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("t5_tx_high", 32'(tx), 32'd1);
    chk("t5_count_zero", 32'(fifo_count), 32'd0);
    repeat (500) step(1'b0, 1'b0, 32'h0);

    // Random traffic, including all-zero and all-one nonces
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       d = 32'h0;
        1:       d = 32'hFFFFFFFF;
        default: d = $urandom;
      endcase
      step(1'b0, ($urandom_range(0, 99) < 3), d);
    end
    drain();

    // Overflow counter saturation under a permanently full FIFO
    step(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 65800; i++) step(1'b0, 1'b1, $urandom);
    chk("t6_ovf_saturated", 32'(overflow_count), 32'h0000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
